// File: rtl/lsu_mem_master_pkg.sv
// Shared encodings for the load/store unit: RV32I funct3 sizes, mcause codes, FSM states.
package lsu_mem_master_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [3:0] CAUSE_LD_MISALIGN = 4'd4;
  localparam logic [3:0] CAUSE_LD_FAULT    = 4'd5;
  localparam logic [3:0] CAUSE_ST_MISALIGN = 4'd6;
  localparam logic [3:0] CAUSE_ST_FAULT    = 4'd7;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_DONE,
    S_FAULT
  } state_t;

endpackage

// File: rtl/lsu_align.sv
// Combinational lane steering: byte enables, replicated store data, alignment/encoding
// checks and sign/zero extension of the read word.
module lsu_align
  import lsu_mem_master_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic        is_store,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata_lanes,
  output logic        misaligned,
  output logic        invalid,
  output logic [31:0] load_data
);

  logic [31:0] shifted;

  assign shifted = rdata >> {addr_lo, 3'b000};

  always_comb begin
    be          = 4'b1111;
    wdata_lanes = wdata;
    misaligned  = 1'b0;
    invalid     = 1'b0;
    load_data   = rdata;
    case (funct3)
      F3_B, F3_BU: begin
        invalid     = is_store && (funct3 == F3_BU);
        wdata_lanes = {4{wdata[7:0]}};
        if (is_store) be = 4'b0001 << addr_lo;
        load_data   = (funct3 == F3_B) ? {{24{shifted[7]}}, shifted[7:0]}
                                       : {24'b0, shifted[7:0]};
      end
      F3_H, F3_HU: begin
        invalid     = is_store && (funct3 == F3_HU);
        misaligned  = addr_lo[0];
        wdata_lanes = {2{wdata[15:0]}};
        if (is_store) be = addr_lo[1] ? 4'b1100 : 4'b0011;
        load_data   = (funct3 == F3_H) ? {{16{shifted[15]}}, shifted[15:0]}
                                       : {16'b0, shifted[15:0]};
      end
      F3_W: begin
        misaligned = |addr_lo;
      end
      default: begin
        invalid = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/lsu_mem_master.sv
// Load/store initiator: stalls the pipeline while a req/ack access to data memory is in
// flight, returns extended load data, and raises misalignment/timeout traps.
module lsu_mem_master
  import lsu_mem_master_pkg::*;
#(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MemReadM,
  input  logic        MemWriteM,
  input  logic [2:0]  funct3M,
  input  logic [31:0] ALUResultM,
  input  logic [31:0] WriteDataM,
  output logic        StallM,
  output logic [31:0] LoadDataM,
  output logic        DoneM,
  output logic        ExcValidM,
  output logic [3:0]  ExcCauseM,
  output logic [31:0] ExcTvalM,
  output logic        mem_req,
  output logic        mem_we,
  output logic [29:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT - 1);

  state_t            state, state_n;
  logic [CNT_W-1:0]  cnt;
  logic [31:0]       addr_q, wdata_q, load_q;
  logic [2:0]        f3_q;
  logic              we_q;
  logic [3:0]        cause_q;

  logic              req, idle;
  logic [2:0]        sel_f3;
  logic              sel_st;
  logic [31:0]       sel_addr, sel_wdata;
  logic [3:0]        al_be;
  logic [31:0]       al_wdata, al_load;
  logic              al_mis, al_inv;

  assign req  = MemReadM | MemWriteM;
  assign idle = (state == S_IDLE);

  // In IDLE the aligner checks the incoming request; afterwards it steers the latched one.
  assign sel_f3    = idle ? funct3M    : f3_q;
  assign sel_st    = idle ? MemWriteM  : we_q;
  assign sel_addr  = idle ? ALUResultM : addr_q;
  assign sel_wdata = idle ? WriteDataM : wdata_q;

  lsu_align u_align (
    .funct3      (sel_f3),
    .is_store    (sel_st),
    .addr_lo     (sel_addr[1:0]),
    .wdata       (sel_wdata),
    .rdata       (mem_rdata),
    .be          (al_be),
    .wdata_lanes (al_wdata),
    .misaligned  (al_mis),
    .invalid     (al_inv),
    .load_data   (al_load)
  );

  always_comb begin
    state_n   = state;
    StallM    = 1'b0;
    LoadDataM = 32'b0;
    DoneM     = 1'b0;
    ExcValidM = 1'b0;
    ExcCauseM = 4'b0;
    ExcTvalM  = 32'b0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = 30'b0;
    mem_be    = 4'b0;
    mem_wdata = 32'b0;
    case (state)
      S_IDLE: begin
        if (req && !rst) begin
          StallM  = 1'b1;
          state_n = (al_inv || al_mis) ? S_FAULT : S_REQ;
        end
      end
      S_REQ: begin
        StallM    = 1'b1;
        mem_req   = 1'b1;
        mem_we    = we_q;
        mem_addr  = addr_q[31:2];
        mem_be    = al_be;
        mem_wdata = al_wdata;
        if (mem_ack)                state_n = S_DONE;
        else if (cnt == CNT_LIMIT)  state_n = S_FAULT;
      end
      S_DONE: begin
        DoneM     = 1'b1;
        LoadDataM = load_q;
        state_n   = S_IDLE;
      end
      S_FAULT: begin
        ExcValidM = 1'b1;
        ExcCauseM = cause_q;
        ExcTvalM  = addr_q;
        state_n   = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      cnt     <= '0;
      addr_q  <= 32'b0;
      wdata_q <= 32'b0;
      load_q  <= 32'b0;
      f3_q    <= 3'b0;
      we_q    <= 1'b0;
      cause_q <= 4'b0;
    end else begin
      state <= state_n;
      case (state)
        S_IDLE: begin
          if (req) begin
            addr_q  <= ALUResultM;
            wdata_q <= WriteDataM;
            f3_q    <= funct3M;
            we_q    <= MemWriteM;
            cnt     <= '0;
            if (al_inv)
              cause_q <= MemWriteM ? CAUSE_ST_FAULT : CAUSE_LD_FAULT;
            else
              cause_q <= MemWriteM ? CAUSE_ST_MISALIGN : CAUSE_LD_MISALIGN;
          end
        end
        S_REQ: begin
          if (mem_ack)
            load_q <= we_q ? 32'b0 : al_load;
          else if (cnt == CNT_LIMIT)
            cause_q <= we_q ? CAUSE_ST_FAULT : CAUSE_LD_FAULT;
          else
            cnt <= cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_mem_master.sv
// Directed plus randomized accesses checked against an arithmetic reference of the
// load/store rules (sizes, lanes, extension, trap causes, timeout).
module tb_lsu_mem_master;

  localparam int TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        MemReadM = 1'b0, MemWriteM = 1'b0;
  logic [2:0]  funct3M = 3'b0;
  logic [31:0] ALUResultM = 32'b0, WriteDataM = 32'b0;
  logic        StallM, DoneM, ExcValidM;
  logic [31:0] LoadDataM, ExcTvalM;
  logic [3:0]  ExcCauseM;
  logic        mem_req, mem_we;
  logic [29:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = 32'b0;

  int compared = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  lsu_mem_master #(.TIMEOUT(TIMEOUT), .CNT_W(5)) dut (
    .clk(clk), .rst(rst),
    .MemReadM(MemReadM), .MemWriteM(MemWriteM), .funct3M(funct3M),
    .ALUResultM(ALUResultM), .WriteDataM(WriteDataM),
    .StallM(StallM), .LoadDataM(LoadDataM), .DoneM(DoneM),
    .ExcValidM(ExcValidM), .ExcCauseM(ExcCauseM), .ExcTvalM(ExcTvalM),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: size in bytes from funct3, lane offset from the low address bits.
  task automatic model(input bit st, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, input logic [31:0] rd,
                       output int cause, output logic [3:0] be,
                       output logic [31:0] wl, output logic [31:0] ld);
    int n, off;
    bit valid;
    logic [31:0] v;
    n   = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : (f3[1:0] == 2'd2) ? 4 : 0;
    off = int'(a % 4);
    valid = st ? (f3 <= 3'd2) : (f3 != 3'd3 && f3 != 3'd6 && f3 != 3'd7);
    if (!valid)               cause = st ? 7 : 5;
    else if ((a % n) != 0)    cause = st ? 6 : 4;
    else                      cause = -1;
    be = 4'hF;
    wl = wd;
    ld = 32'b0;
    if (valid) begin
      if (st) be = 4'(((1 << n) - 1) << off);
      for (int i = 0; i < 4; i++) wl[8*i +: 8] = wd[8*(i % n) +: 8];
      v = rd >> (8 * off);
      if (n == 4) ld = v;
      else begin
        ld = v & ((32'd1 << (8 * n)) - 1);
        if (!f3[2] && v[8*n-1]) ld = ld | ~((32'd1 << (8 * n)) - 1);
      end
    end
  endtask

  // One access from the IDLE cycle to completion; ack_at is the REQ cycle index of the ack.
  task automatic access(input bit rd_en, input bit wr_en, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd,
                        input logic [31:0] rdat, input int ack_at);
    int cause, k, exp_k;
    logic [3:0] be;
    logic [31:0] wl, ld;
    bit st, acked, fin;
    st = wr_en;
    model(st, f3, a, wd, rdat, cause, be, wl, ld);
    @(posedge clk); #1;
    MemReadM = rd_en; MemWriteM = wr_en; funct3M = f3; ALUResultM = a; WriteDataM = wd;
    mem_ack = 1'($urandom % 2); mem_rdata = $urandom;
    #1;
    chk("idle_stall", StallM, 1);
    chk("idle_no_req", mem_req, 0);
    chk("idle_no_done", DoneM, 0);
    if (cause >= 0) begin
      @(posedge clk); #1;
      mem_ack = 1'b0; MemReadM = 1'b0; MemWriteM = 1'b0;
      #1;
      chk("trap_valid", ExcValidM, 1);
      chk("trap_cause", ExcCauseM, 32'(cause));
      chk("trap_tval", ExcTvalM, a);
      chk("trap_stall", StallM, 0);
      chk("trap_no_req", mem_req, 0);
    end else begin
      k = 0; acked = 1'b0; fin = 1'b0;
      while (!fin) begin
        @(posedge clk); #1;
        mem_ack = (k == ack_at); mem_rdata = (k == ack_at) ? rdat : $urandom;
        #1;
        chk("req_valid", mem_req, 1);
        chk("req_stall", StallM, 1);
        chk("req_we", mem_we, st);
        chk("req_addr", mem_addr, a[31:2]);
        chk("req_be", mem_be, be);
        if (st) chk("req_wdata", mem_wdata, wl);
        acked = mem_ack;
        if (acked || k == TIMEOUT - 1) fin = 1'b1;
        k++;
      end
      exp_k = (ack_at >= 0 && ack_at < TIMEOUT) ? ack_at + 1 : TIMEOUT;
      chk("req_cycles", k, exp_k);
      @(posedge clk); #1;
      mem_ack = 1'b0; MemReadM = 1'b0; MemWriteM = 1'b0;
      #1;
      chk("end_stall", StallM, 0);
      if (acked) begin
        chk("done_pulse", DoneM, 1);
        chk("done_data", LoadDataM, st ? 32'b0 : ld);
        chk("done_no_trap", ExcValidM, 0);
      end else begin
        chk("tmo_valid", ExcValidM, 1);
        chk("tmo_cause", ExcCauseM, st ? 32'd7 : 32'd5);
        chk("tmo_tval", ExcTvalM, a);
        chk("tmo_no_done", DoneM, 0);
      end
    end
    @(posedge clk); #2;
    chk("after_idle_stall", StallM, 0);
    chk("after_idle_req", mem_req, 0);
    chk("after_idle_done", DoneM | ExcValidM, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit rd, wr;
    int sel, ack_at;
    logic [31:0] a;

    // Reset held with a pending load: every output must stay low.
    MemReadM = 1'b1;
    #12;
    chk("rst_stall", StallM, 0);
    chk("rst_req", mem_req, 0);
    chk("rst_done", DoneM, 0);
    chk("rst_exc", ExcValidM, 0);
    chk("rst_load", LoadDataM, 0);
    MemReadM = 1'b0;
    @(posedge clk); #1 rst = 1'b0;

    access(1, 0, 3'b010, 32'h10, 32'h0, 32'hDEADBEEF, 0);
    access(1, 0, 3'b000, 32'h13, 32'h0, 32'h80FF_0000, 0);
    access(1, 0, 3'b100, 32'h13, 32'h0, 32'h80FF_0000, 0);
    access(0, 1, 3'b001, 32'h22, 32'h1234ABCD, 32'h0, 3);
    access(1, 0, 3'b010, 32'h6, 32'h0, 32'h0, 0);
    access(0, 1, 3'b010, 32'h5, 32'h0, 32'h0, 0);
    access(1, 0, 3'b010, 32'h100, 32'h0, 32'h0, -1);
    access(1, 0, 3'b101, 32'h102, 32'h0, 32'h8001_7FFF, TIMEOUT - 1);
    access(1, 1, 3'b000, 32'h41, 32'hA5, 32'h0, 1);

    // Reset in the middle of a REQ window abandons the access.
    @(posedge clk); #1;
    MemReadM = 1'b1; funct3M = 3'b010; ALUResultM = 32'h40; mem_ack = 1'b0;
    repeat (3) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("midrst_req", mem_req, 0);
    chk("midrst_stall", StallM, 0);
    MemReadM = 1'b0;
    @(posedge clk); #1 rst = 1'b0;
    #1;
    chk("midrst_done", DoneM, 0);
    chk("midrst_exc", ExcValidM, 0);

    access(1, 0, 3'b001, 32'h2E, 32'h0, 32'hC0DE_1234, 2);
    access(0, 1, 3'b011, 32'h8, 32'h0, 32'h0, 0);

    for (int i = 0; i < 60; i++) begin
      sel = $urandom_range(0, 2);
      rd = (sel != 1);
      wr = (sel != 0);
      a = $urandom;
      case ($urandom_range(0, 7))
        0:       ack_at = -1;
        1:       ack_at = TIMEOUT - 1;
        default: ack_at = $urandom_range(0, 5);
      endcase
      access(rd, wr, 3'($urandom_range(0, 7)), a, $urandom, $urandom, ack_at);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/lsu_mem_master.md
Name: lsu_mem_master

Overview:
- Load/store initiator between the pipeline MEM stage and the data-memory responder.
- Aligns byte/half/word accesses, generates byte enables and replicated store data, runs a req/ack handshake with wait states and stalls the pipeline meanwhile.
- Sign/zero-extends load data.
- Reports misaligned or timed-out accesses to the CSR trap logic (cause, tval).

Parameters:
- TIMEOUT, 16, max cycles in REQ waiting for mem_ack before access fault (must be >= 1).
- CNT_W, 5, width of the wait counter (must hold TIMEOUT).

Ports:
- clk  in  1  clock.
- rst  in  1  reset: asynchronous, active-high.
- MemReadM  in  1  load request from MEM stage.
- MemWriteM  in  1  store request from MEM stage.
- funct3M  in  3  access size/sign (RV32I load/store encoding).
- ALUResultM  in  32  byte address.
- WriteDataM  in  32  store data (rs2).
- StallM  out  1  hold IF..MEM stages.
- LoadDataM  out  32  extended load result, valid while DoneM=1.
- DoneM  out  1  one-cycle completion pulse.
- ExcValidM  out  1  one-cycle trap request.
- ExcCauseM  out  4  mcause code.
- ExcTvalM  out  32  faulting address.
- mem_req  out  1  request to data memory.
- mem_we  out  1  1 = write.
- mem_addr  out  30  word address = ALUResultM[31:2].
- mem_be  out  4  byte enables.
- mem_wdata  out  32  lane-aligned store data.
- mem_ack  in  1  responder accepted (write) / data valid (read).
- mem_rdata  in  32  read word.

Behaviour:
- Reset (async, rst=1): state IDLE, wait counter 0, all outputs 0 (mem_req drops immediately, LoadDataM=0). An access in flight is abandoned with no Done and no exception.
- Request:
  - req = MemReadM | MemWriteM.
  - Both high → treated as a store.
- Alignment:
  - LH/LHU/SH need addr[0]=0.
  - LW/SW need addr[1:0]=0.
  - Bytes are always aligned.
- funct3 handling:
  - Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Stores: 000 SB, 001 SH, 010 SW.
  - Any other funct3 is an access fault.
- States: IDLE, REQ, DONE, FAULT.
- IDLE:
  - No req: StallM=0, stay.
  - req, valid and aligned: StallM=1; latch addr/we/be/wdata/funct3; counter 0 → REQ.
  - req, misaligned: StallM=1 → FAULT with cause 4 (load) / 6 (store).
  - req, invalid funct3: StallM=1 → FAULT with cause 5 (load) / 7 (store).
- REQ:
  - mem_req=1; mem_we/addr/be/wdata driven from latched values, stable until ack. StallM=1.
  - mem_ack=1: capture extended read data → DONE.
  - Otherwise counter+1. When counter reaches TIMEOUT-1 with no ack → FAULT with cause 5/7.
  - An ack in the same cycle as the timeout limit wins (→ DONE).
- DONE: DoneM=1; LoadDataM valid (0 for stores); StallM=0 → IDLE.
- FAULT: ExcValidM=1; ExcCauseM and ExcTvalM (=latched byte address) valid; StallM=0; no memory access → IDLE.
- mem_ack outside REQ is ignored.
- Byte enables:
  - SB: be = 0001 << addr[1:0]; wdata = byte replicated ×4.
  - SH: be = 0011 (addr[1]=0) or 1100; wdata = half replicated ×2.
  - SW: be = 1111.
  - Loads: be=1111.
- Load extract: select byte/half by addr[1:0]. LB/LH sign-extend; LBU/LHU zero-extend.
- Latency: aligned access with mem_ack in the first REQ cycle stalls 2 cycles; DoneM is in the 3rd cycle.

Decomposition:
- Shared package: funct3 encodings (F3_B/H/W/BU/HU), mcause constants (CAUSE_LD_MISALIGN=4, LD_FAULT=5, ST_MISALIGN=6, ST_FAULT=7), state enum.
- One combinational sub-module, lsu_align: from funct3/addr/wdata/rdata produces be, wdata lanes, misaligned flag, extended load data. The FSM and counter stay in the top.

Test Plan:
- LW addr 0x10, responder acks in first REQ cycle with 0xDEADBEEF → mem_addr=0x4, be=1111, StallM high 2 cycles, DoneM with LoadDataM=0xDEADBEEF.
- LB addr 0x13 / LBU addr 0x13, rdata 0x80FF_0000 → be=1111; LB gives 0xFFFFFF80, LBU gives 0x00000080.
- SH addr 0x22, WriteDataM 0x1234ABCD, ack after 3 wait cycles → mem_we=1, be=1100, wdata=0xABCDABCD held stable 4 REQ cycles, then DoneM.
- LW addr 0x6 → no mem_req; next cycle ExcValidM=1, cause 4, tval 0x6. SW addr 0x5 → cause 6.
- Load with no ack, TIMEOUT=16 → mem_req high exactly 16 cycles, then ExcValidM with cause 5. Repeat with ack on the 16th cycle → DoneM, no exception.
- rst asserted mid-REQ → mem_req/StallM go 0 asynchronously; after release the next request proceeds normally; funct3=011 store → cause 7.
